mc_ctrl: RTL and testbench

- Multi-cycle sequencer for the CPU datapath: Moore FSM that breaks each instruction into fetch, decode, execute, memory and write-back steps.
- Drives every datapath mux select and write enable.
- Stalls on the memory/IO handshake (MIO_ready).
- Flags illegal opcodes and memory timeouts.
- Replaces the single-cycle opcode decoder and sits between instruction register, ALU, register file and memory bus.

---
 rtl/mc_pkg.sv | 49 ++++
 rtl/mc_wait_cnt.sv | 33 +++
 rtl/mc_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : State, opcode and datapath select encodings for mc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    localparam logic [3:0] S_IF    = 4'd0;
    localparam logic [3:0] S_ID    = 4'd1;
    localparam logic [3:0] S_MADDR = 4'd2;
    localparam logic [3:0] S_MRD   = 4'd3;
    localparam logic [3:0] S_MWB   = 4'd4;
    localparam logic [3:0] S_MWR   = 4'd5;
    localparam logic [3:0] S_EX_R  = 4'd6;
    localparam logic [3:0] S_RWB   = 4'd7;
    localparam logic [3:0] S_BR    = 4'd8;
    localparam logic [3:0] S_JMP   = 4'd9;
    localparam logic [3:0] S_EX_I  = 4'd10;
    localparam logic [3:0] S_IWB   = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // States in which the FSM waits on the memory/IO handshake.
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_IF) || (s == S_MRD) || (s == S_MWR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mc_wait_cnt
// Description : Memory-stall counter; expire flags the last allowed stall.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_wait_cnt #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int unsigned c_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    logic [c_W-1:0] r_count;

    // A stall that would bring the count to WAIT_MAX aborts the access.
    assign expire = inc && (r_count == c_W'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + c_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle Moore sequencer driving the CPU datapath controls.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             MIO_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNE,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             CPU_MIO,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUop,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic             r_illegal;
    logic             r_timeout;
    logic [CNT_W-1:0] r_retired;
    logic             w_inc;
    logic             w_clear;
    logic             w_expire;
    logic             w_bad_op;
    logic             w_retire;
    logic             w_unused_zero;

    // The branch condition is resolved in the datapath, not here.
    assign w_unused_zero = zero;

    assign w_inc   = is_mem_state(r_state) && !MIO_ready;
    assign w_clear = (w_next != r_state) || w_expire;

    mc_wait_cnt #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .inc    (w_inc),
        .expire (w_expire)
    );

    always_comb begin
        w_next   = r_state;
        w_bad_op = 1'b0;
        w_retire = 1'b0;
        case (r_state)
            S_IF: begin
                if (MIO_ready) w_next = S_ID;
            end
            S_ID: begin
                case (opcode)
                    OP_R:           w_next = S_EX_R;
                    OP_LW, OP_SW:   w_next = S_MADDR;
                    OP_BEQ, OP_BNE: w_next = S_BR;
                    OP_J:           w_next = S_JMP;
                    OP_ADDI:        w_next = S_EX_I;
                    default: begin
                        w_next   = S_IF;
                        w_bad_op = 1'b1;
                    end
                endcase
            end
            S_MADDR: w_next = (opcode == OP_SW) ? S_MWR : S_MRD;
            S_MRD: begin
                if (MIO_ready)     w_next = S_MWB;
                else if (w_expire) w_next = S_IF;
            end
            S_MWR: begin
                if (MIO_ready) begin
                    w_next   = S_IF;
                    w_retire = 1'b1;
                end else if (w_expire) begin
                    w_next = S_IF;
                end
            end
            S_EX_R: w_next = S_RWB;
            S_EX_I: w_next = S_IWB;
            S_MWB, S_RWB, S_BR, S_JMP, S_IWB: begin
                w_next   = S_IF;
                w_retire = 1'b1;
            end
            default: w_next = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IF;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_bad_op) r_illegal <= 1'b1;
            if (w_expire) r_timeout <= 1'b1;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Outputs follow the state only; IF gates its loads with the handshake
    // and reset silences everything so an abandoned access issues no write.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        CPU_MIO     = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        ALUop       = ALU_ADD;
        PCSource    = PCS_ALU;
        if (!reset) begin
            case (r_state)
                S_IF: begin
                    MemRead = 1'b1;
                    CPU_MIO = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = MIO_ready;
                    PCWrite = MIO_ready;
                end
                S_ID: ALUSrcB = SRCB_IMM_SH;
                S_MADDR, S_EX_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                    CPU_MIO = 1'b1;
                end
                S_MWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    CPU_MIO  = 1'b1;
                end
                S_EX_R: begin
                    ALUSrcA = 1'b1;
                    ALUop   = ALU_FUNCT;
                end
                S_RWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BR: begin
                    ALUSrcA     = 1'b1;
                    ALUop       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCS_ALUOUT;
                    BranchNE    = opcode[0];
                end
                S_JMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCS_JUMP;
                end
                S_IWB: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign timeout = r_timeout;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Directed self-checking bench for mc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    // Control word: PCWrite,PCWriteCond,BranchNE,IorD,MemRead,MemWrite,CPU_MIO,
    // IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB[2],ALUop[2],PCSource[2]
    localparam logic [17:0] c_E_ZERO  = 18'b0_0_0_0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [17:0] c_E_IF_GO = 18'b1_0_0_0_1_0_1_1_0_0_0_0_01_00_00;
    localparam logic [17:0] c_E_IF_ST = 18'b0_0_0_0_1_0_1_0_0_0_0_0_01_00_00;
    localparam logic [17:0] c_E_ID    = 18'b0_0_0_0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [17:0] c_E_MADDR = 18'b0_0_0_0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [17:0] c_E_MRD   = 18'b0_0_0_1_1_0_1_0_0_0_0_0_00_00_00;
    localparam logic [17:0] c_E_MWB   = 18'b0_0_0_0_0_0_0_0_0_1_1_0_00_00_00;
    localparam logic [17:0] c_E_MWR   = 18'b0_0_0_1_0_1_1_0_0_0_0_0_00_00_00;
    localparam logic [17:0] c_E_EX_R  = 18'b0_0_0_0_0_0_0_0_0_0_0_1_00_10_00;
    localparam logic [17:0] c_E_RWB   = 18'b0_0_0_0_0_0_0_0_1_0_1_0_00_00_00;
    localparam logic [17:0] c_E_BNE   = 18'b0_1_1_0_0_0_0_0_0_0_0_1_00_01_01;
    localparam logic [17:0] c_E_IWB   = 18'b0_0_0_0_0_0_0_0_0_0_1_0_00_00_00;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        MIO_ready;
    logic        PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite;
    logic        CPU_MIO, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUop, PCSource;
    logic [3:0]  state;
    logic        illegal, timeout;
    logic [31:0] retired;
    logic [17:0] w_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    mc_ctrl #(
        .WAIT_MAX (15),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .zero        (zero),
        .MIO_ready   (MIO_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .BranchNE    (BranchNE),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .CPU_MIO     (CPU_MIO),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUop       (ALUop),
        .PCSource    (PCSource),
        .state       (state),
        .illegal     (illegal),
        .timeout     (timeout),
        .retired     (retired)
    );

    assign w_ctrl = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite,
                     CPU_MIO, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                     ALUSrcB, ALUop, PCSource};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle's state and control word mid-cycle, then advance.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] c);
        #1;
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".ctrl"}, 32'(w_ctrl), 32'(c));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        opcode    = 6'b000000;
        zero      = 1'b0;
        MIO_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst.illegal", 32'(illegal), 32'd0);
        check("rst.timeout", 32'(timeout), 32'd0);
        check("rst.retired", retired, 32'd0);
        cyc("rst", 4'd0, c_E_ZERO);

        // R-type, zero-wait
        reset     = 1'b0;
        MIO_ready = 1'b1;
        opcode    = 6'b000000;
        cyc("r.if", 4'd0, c_E_IF_GO);
        cyc("r.id", 4'd1, c_E_ID);
        cyc("r.ex", 4'd6, c_E_EX_R);
        check("r.retired_pre", retired, 32'd0);
        cyc("r.wb", 4'd7, c_E_RWB);
        check("r.retired", retired, 32'd1);

        // lw with three stall cycles in MRD
        opcode = 6'b100011;
        cyc("lw.if", 4'd0, c_E_IF_GO);
        cyc("lw.id", 4'd1, c_E_ID);
        MIO_ready = 1'b0;
        cyc("lw.maddr", 4'd2, c_E_MADDR);
        for (int i = 0; i < 3; i++) cyc("lw.mrd_wait", 4'd3, c_E_MRD);
        MIO_ready = 1'b1;
        cyc("lw.mrd_done", 4'd3, c_E_MRD);
        cyc("lw.mwb", 4'd4, c_E_MWB);
        check("lw.retired", retired, 32'd2);

        // bne
        opcode = 6'b000101;
        cyc("bne.if", 4'd0, c_E_IF_GO);
        cyc("bne.id", 4'd1, c_E_ID);
        cyc("bne.br", 4'd8, c_E_BNE);
        check("bne.state", 32'(state), 32'd0);
        check("bne.retired", retired, 32'd3);

        // illegal opcode
        opcode = 6'b111111;
        cyc("ill.if", 4'd0, c_E_IF_GO);
        cyc("ill.id", 4'd1, c_E_ID);
        check("ill.state", 32'(state), 32'd0);
        check("ill.flag", 32'(illegal), 32'd1);
        check("ill.retired", retired, 32'd3);

        // sw with memory never ready: abort after 15 MWR cycles
        opcode = 6'b101011;
        cyc("sw.if", 4'd0, c_E_IF_GO);
        cyc("sw.id", 4'd1, c_E_ID);
        MIO_ready = 1'b0;
        cyc("sw.maddr", 4'd2, c_E_MADDR);
        check("sw.timeout_pre", 32'(timeout), 32'd0);
        for (int i = 0; i < 15; i++) cyc("sw.mwr", 4'd5, c_E_MWR);
        check("sw.state", 32'(state), 32'd0);
        check("sw.timeout", 32'(timeout), 32'd1);
        check("sw.retired", retired, 32'd3);
        check("sw.illegal_sticky", 32'(illegal), 32'd1);

        // addi after the abort, with one fetch stall
        opcode = 6'b001000;
        cyc("addi.if_stall", 4'd0, c_E_IF_ST);
        MIO_ready = 1'b1;
        cyc("addi.if", 4'd0, c_E_IF_GO);
        cyc("addi.id", 4'd1, c_E_ID);
        cyc("addi.ex", 4'd10, c_E_MADDR);
        cyc("addi.wb", 4'd11, c_E_IWB);
        check("addi.retired", retired, 32'd4);
        check("addi.timeout_sticky", 32'(timeout), 32'd1);

        // lw completing on the 15th MRD cycle is not a timeout
        opcode = 6'b100011;
        cyc("lwb.if", 4'd0, c_E_IF_GO);
        cyc("lwb.id", 4'd1, c_E_ID);
        MIO_ready = 1'b0;
        cyc("lwb.maddr", 4'd2, c_E_MADDR);
        for (int i = 0; i < 14; i++) cyc("lwb.mrd_wait", 4'd3, c_E_MRD);
        MIO_ready = 1'b1;
        cyc("lwb.mrd_done", 4'd3, c_E_MRD);
        cyc("lwb.mwb", 4'd4, c_E_MWB);
        check("lwb.retired", retired, 32'd5);

        // reset in the middle of an MRD stall
        cyc("rsm.if", 4'd0, c_E_IF_GO);
        cyc("rsm.id", 4'd1, c_E_ID);
        MIO_ready = 1'b0;
        cyc("rsm.maddr", 4'd2, c_E_MADDR);
        cyc("rsm.mrd", 4'd3, c_E_MRD);
        reset = 1'b1;
        cyc("rsm.mrd_rst", 4'd3, c_E_ZERO);
        check("rsm.retired", retired, 32'd0);
        check("rsm.illegal", 32'(illegal), 32'd0);
        check("rsm.timeout", 32'(timeout), 32'd0);
        cyc("rsm.after", 4'd0, c_E_ZERO);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
